// File: rtl/sobol_stream_arbiter.sv
// ---------------------------------------------------------------------------
// sobol_stream_arbiter
//
// Shares one Sobol RNG between NREQ stochastic-bitstream requesters. Each job
// is granted round-robin, clears the RNG, runs it for a window of 2^WLOG
// un-stalled cycles and streams bit = (operand > rng_val) to the granted
// requester. The number of ones emitted is reported with the completion pulse.
//
// Ports
//   clk       clock
//   rst       synchronous active-high reset
//   req       per-requester job request (level, held until its done pulse)
//   src       per-requester operand, slice i = src[i*RWID +: RWID]
//   hold      stall; freezes the running window
//   rng_val   current RNG output
//   rng_clr   one-cycle RNG restart pulse
//   rng_en    RNG advance enable
//   gnt       one-hot grant, zero when idle
//   bit_out   stochastic bit for the granted requester
//   bit_vld   bit_out qualifier
//   done      one-hot, one-cycle completion pulse
//   ones_cnt  ones emitted in the finished window (valid with done)
//   busy      high whenever the controller is not idle
// ---------------------------------------------------------------------------
module sobol_stream_arbiter #(
   parameter int NREQ = 4,
   parameter int RWID = 8,
   parameter int WLOG = RWID
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*RWID-1:0] src,
   input  logic                 hold,
   input  logic [RWID-1:0]      rng_val,
   output logic                 rng_clr,
   output logic                 rng_en,
   output logic [NREQ-1:0]      gnt,
   output logic                 bit_out,
   output logic                 bit_vld,
   output logic [NREQ-1:0]      done,
   output logic [WLOG:0]        ones_cnt,
   output logic                 busy
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CLR,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     ptr_q, ptr_d;
   logic [PW-1:0]     win_q, win_d;
   logic [RWID-1:0]   op_q, op_d;
   logic [WLOG-1:0]   wcnt_q, wcnt_d;
   logic [WLOG:0]     ones_q, ones_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic              rng_clr_q, rng_clr_d;
   logic              bit_out_q, bit_out_d;
   logic              bit_vld_q, bit_vld_d;
   logic [NREQ-1:0]   done_q, done_d;
   logic [WLOG:0]     ones_cnt_q, ones_cnt_d;
   logic              busy_q, busy_d;

   // Operand slices as an array so the winner can be indexed directly.
   logic [RWID-1:0] src_arr [NREQ];

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_src
         assign src_arr[gi] = src[gi*RWID +: RWID];
      end
   endgenerate

   // Round-robin search: rotate req so the pointer position sits at bit 0,
   // take the lowest set bit, then rotate the offset back.
   logic [2*NREQ-1:0] req_dbl;
   logic [NREQ-1:0]   req_rot;
   logic              pick_vld;
   logic [PW-1:0]     pick_off;
   logic [PW:0]       pick_sum;
   logic [PW-1:0]     pick_idx;

   assign req_dbl = {req, req} >> ptr_q;
   assign req_rot = req_dbl[NREQ-1:0];

   always_comb begin
      pick_vld = 1'b0;
      pick_off = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!pick_vld && req_rot[k]) begin
            pick_vld = 1'b1;
            pick_off = PW'(k);
         end
      end
   end

   always_comb begin
      pick_sum = {1'b0, ptr_q} + {1'b0, pick_off};
      if (pick_sum >= (PW+1)'(NREQ)) begin
         pick_sum = pick_sum - (PW+1)'(NREQ);
      end
      pick_idx = pick_sum[PW-1:0];
   end

   logic cmp;
   logic win_req;
   logic run_step;

   assign cmp      = (op_q > rng_val);
   assign win_req  = req[win_q];
   // A window step happens only in RUN, un-stalled, with the job still wanted.
   assign run_step = (state_q == ST_RUN) && !hold && win_req;

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      win_d      = win_q;
      op_d       = op_q;
      wcnt_d     = wcnt_q;
      ones_d     = ones_q;
      gnt_d      = gnt_q;
      rng_clr_d  = 1'b0;
      bit_out_d  = 1'b0;
      bit_vld_d  = 1'b0;
      done_d     = '0;
      ones_cnt_d = ones_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               op_d      = src_arr[pick_idx];
               win_d     = pick_idx;
               gnt_d     = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
               ptr_d     = (pick_idx == PW'(NREQ-1)) ? '0 : pick_idx + PW'(1);
               rng_clr_d = 1'b1;
               state_d   = ST_CLR;
            end
         end
         ST_CLR: begin
            wcnt_d = '0;
            ones_d = '0;
            if (!win_req) begin
               gnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!win_req) begin
               gnt_d   = '0;
               state_d = ST_IDLE;
            end else if (!hold) begin
               bit_out_d = cmp;
               bit_vld_d = 1'b1;
               wcnt_d    = wcnt_q + WLOG'(1);
               ones_d    = ones_q + {{WLOG{1'b0}}, cmp};
               if (wcnt_q == {WLOG{1'b1}}) begin
                  // Final count includes the bit being emitted this cycle,
                  // so it lines up with the last bit_vld.
                  done_d     = gnt_q;
                  ones_cnt_d = ones_q + {{WLOG{1'b0}}, cmp};
                  state_d    = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            gnt_d   = '0;
            state_d = ST_IDLE;
         end
         default: begin
            gnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         win_q      <= '0;
         op_q       <= '0;
         wcnt_q     <= '0;
         ones_q     <= '0;
         gnt_q      <= '0;
         rng_clr_q  <= 1'b0;
         bit_out_q  <= 1'b0;
         bit_vld_q  <= 1'b0;
         done_q     <= '0;
         ones_cnt_q <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         win_q      <= win_d;
         op_q       <= op_d;
         wcnt_q     <= wcnt_d;
         ones_q     <= ones_d;
         gnt_q      <= gnt_d;
         rng_clr_q  <= rng_clr_d;
         bit_out_q  <= bit_out_d;
         bit_vld_q  <= bit_vld_d;
         done_q     <= done_d;
         ones_cnt_q <= ones_cnt_d;
         busy_q     <= busy_d;
      end
   end

   // rng_en must track hold in the same cycle, otherwise the RNG would drift
   // out of step with the window counter; it is therefore not registered.
   assign rng_en   = run_step;
   assign rng_clr  = rng_clr_q;
   assign gnt      = gnt_q;
   assign bit_out  = bit_out_q;
   assign bit_vld  = bit_vld_q;
   assign done     = done_q;
   assign ones_cnt = ones_cnt_q;
   assign busy     = busy_q;

endmodule
